// File: rtl/hazard_control_unit.sv
// Stall/bubble/flush sequencing for the five-stage pipeline: load-use, MEM-resolved branches, multi-cycle EX ops.
// Define HAZARD_MC_EN to compile in multi-cycle sequencing, the watchdog and mc_error.
module hazard_control_unit #(
    parameter int CNT_W      = 16,
    parameter int MC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             read_ex,
    input  logic             mc_op_ex,
    input  logic             mc_done,
    input  logic             branch_taken_mem,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mc_start,
    output logic             mc_abort,
    output logic             mc_error,
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic load_use;
    logic stall_inc;
    logic flush_inc;

    assign load_use = read_ex && (rd_ex != 5'd0) && ((rd_ex == rs1_id) || (rd_ex == rs2_id));

`ifdef HAZARD_MC_EN
    typedef enum logic {RUN, MC_WAIT} state_t;
    localparam logic [15:0] WD_LAST = 16'(MC_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wd;
    logic [15:0] wd_nxt;
    logic        err_set;
`else
    // Without multi-cycle support the sequencer never leaves RUN.
    logic unused_mc;
    assign unused_mc = mc_op_ex ^ mc_done;
    assign mc_error  = 1'b0;
`endif

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mc_start     = 1'b0;
        mc_abort     = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
`ifdef HAZARD_MC_EN
        state_nxt    = state;
        wd_nxt       = wd;
        err_set      = 1'b0;
`endif
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (branch_taken_mem) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            flush_inc    = 1'b1;
`ifdef HAZARD_MC_EN
            mc_abort     = (state == MC_WAIT);
            state_nxt    = RUN;
            wd_nxt       = 16'd0;
        end else if (state == MC_WAIT) begin
            if (mc_done) begin
                state_nxt = RUN;
                wd_nxt    = 16'd0;
            end else if (wd == WD_LAST) begin
                // Timed out: drop the instruction and let the pipeline move on.
                mc_abort     = 1'b1;
                ex_mem_flush = 1'b1;
                err_set      = 1'b1;
                state_nxt    = RUN;
                wd_nxt       = 16'd0;
            end else begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_flush = 1'b1;
                stall_inc    = 1'b1;
                wd_nxt       = wd + 16'd1;
            end
        end else if (mc_op_ex) begin
            mc_start  = 1'b1;
            state_nxt = MC_WAIT;
            wd_nxt    = 16'd0;
`endif
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_stall_cnt <= '0;
            flush_cnt      <= '0;
        end else begin
            if (stall_inc && (load_stall_cnt != {CNT_W{1'b1}}))
                load_stall_cnt <= load_stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

`ifdef HAZARD_MC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wd       <= 16'd0;
            mc_error <= 1'b0;
        end else begin
            state    <= state_nxt;
            wd       <= wd_nxt;
            mc_error <= mc_error | err_set;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit; multi-cycle steps follow HAZARD_MC_EN.
`timescale 1ns/1ps
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic       read_ex = 1'b0, mc_op_ex = 1'b0, mc_done = 1'b0, branch_taken_mem = 1'b0;

    logic        pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic        mc_start, mc_abort, mc_error;
    logic [15:0] load_stall_cnt, flush_cnt;

    logic       s_pc_write, s_if_id_write, s_id_ex_write, s_if_id_flush, s_id_ex_flush, s_ex_mem_flush;
    logic       s_mc_start, s_mc_abort, s_mc_error;
    logic [1:0] s_load_stall_cnt, s_flush_cnt;

    int tests = 0;
    int fails = 0;

    hazard_control_unit #(.CNT_W(16), .MC_TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .read_ex(read_ex), .mc_op_ex(mc_op_ex), .mc_done(mc_done), .branch_taken_mem(branch_taken_mem),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .mc_start(mc_start), .mc_abort(mc_abort), .mc_error(mc_error),
        .load_stall_cnt(load_stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_control_unit #(.CNT_W(2), .MC_TIMEOUT(4)) u_sat (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .read_ex(read_ex), .mc_op_ex(mc_op_ex), .mc_done(mc_done), .branch_taken_mem(branch_taken_mem),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_ex_write(s_id_ex_write),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush),
        .mc_start(s_mc_start), .mc_abort(s_mc_abort), .mc_error(s_mc_error),
        .load_stall_cnt(s_load_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic ld, input logic mc, input logic done, input logic br);
        rs1_id = r1; rs2_id = r2; rd_ex = rd;
        read_ex = ld; mc_op_ex = mc; mc_done = done; branch_taken_mem = br;
        #1;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_pc_write", 64'(pc_write), 64'(1'b0));
        chk("rst_id_ex_write", 64'(id_ex_write), 64'(1'b0));
        chk("rst_flushes", 64'({if_id_flush, id_ex_flush, ex_mem_flush}), 64'(3'b111));
        chk("rst_mc", 64'({mc_start, mc_abort, mc_error}), 64'(3'b000));
        chk("rst_cnts", 64'({load_stall_cnt, flush_cnt}), 64'(32'h0));
        tick();
        rst = 1'b0;
        #1;
        chk("run_writes", 64'({pc_write, if_id_write, id_ex_write}), 64'(3'b111));
        chk("run_flushes", 64'({if_id_flush, id_ex_flush, ex_mem_flush}), 64'(3'b000));

        // Load-use hit on rs2
        drive(5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_hit_cmd", 64'({pc_write, if_id_write, id_ex_write, id_ex_flush, ex_mem_flush}), 64'(5'b00110));
        tick();
        drive(5'd3, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_after_bubble", 64'({pc_write, if_id_write, id_ex_flush}), 64'(3'b110));
        chk("lu_stall_cnt", 64'(load_stall_cnt), 64'(16'd1));

        // Load-use non-hits
        drive(5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_rd0", 64'({pc_write, id_ex_flush}), 64'(2'b10));
        tick();
        drive(5'd7, 5'd9, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_noload", 64'({pc_write, id_ex_flush}), 64'(2'b10));
        tick();
        chk("lu_nohit_cnts", 64'({load_stall_cnt, flush_cnt}), 64'({16'd1, 16'd0}));

        // Branch beats a load-use match
        drive(5'd7, 5'd9, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("br_flushes", 64'({if_id_flush, id_ex_flush, ex_mem_flush}), 64'(3'b111));
        chk("br_writes", 64'({pc_write, if_id_write, id_ex_write}), 64'(3'b111));
        tick();
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("br_cnts", 64'({load_stall_cnt, flush_cnt}), 64'({16'd1, 16'd1}));

`ifdef HAZARD_MC_EN
        // Multi-cycle op: start cycle 0, done cycle 4
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("mc_start_pulse", 64'({mc_start, pc_write, if_id_write, id_ex_write, ex_mem_flush}), 64'(5'b11110));
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("mc_hold", 64'({mc_start, pc_write, if_id_write, id_ex_write, ex_mem_flush}), 64'(5'b00001));
            tick();
        end
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("mc_release", 64'({mc_start, mc_abort, pc_write, if_id_write, id_ex_write, ex_mem_flush}), 64'(6'b001110));
        tick();
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mc_back_run", 64'({mc_start, pc_write, ex_mem_flush}), 64'(3'b010));
        chk("mc_stall_cnt", 64'(load_stall_cnt), 64'(16'd4));
        tick();

        // Branch aborts MC_WAIT
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("brab_cmd", 64'({mc_abort, mc_start, pc_write, if_id_flush, id_ex_flush, ex_mem_flush}), 64'(6'b101111));
        tick();
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("brab_run", 64'({mc_abort, mc_error, pc_write, ex_mem_flush}), 64'(4'b0010));
        chk("brab_flush_cnt", 64'(flush_cnt), 64'(16'd2));

        // Watchdog timeout, MC_TIMEOUT = 4
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("to_hold", 64'({mc_abort, pc_write}), 64'(2'b00));
            tick();
        end
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("to_abort", 64'({mc_abort, ex_mem_flush, pc_write, if_id_write, id_ex_write, mc_error}), 64'(6'b111110));
        tick();
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_run", 64'({mc_abort, mc_error, pc_write, ex_mem_flush}), 64'(4'b0110));
        chk("to_stall_cnt", 64'(load_stall_cnt), 64'(16'd7));
        tick(); tick();
        chk("to_sticky", 64'(mc_error), 64'(1'b1));

        // rst during MC_WAIT: no abort
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_wait_cmd", 64'({mc_abort, pc_write, id_ex_flush, mc_error}), 64'(4'b0010));
`else
        // Multi-cycle inputs have no effect
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("nomc_cmd", 64'({mc_start, mc_abort, pc_write, ex_mem_flush}), 64'(4'b0010));
        tick();
        chk("nomc_run", 64'({mc_error, pc_write, id_ex_write}), 64'(3'b011));
        rst = 1'b1;
        #1;
`endif
        tick();
        rst = 1'b0;
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst2_state", 64'({mc_error, mc_start, pc_write, id_ex_write, ex_mem_flush}), 64'(5'b00110));
        chk("rst2_cnts", 64'({load_stall_cnt, flush_cnt}), 64'(32'h0));

        // Saturation: five flushes into a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_flush_cnt", 64'(s_flush_cnt), 64'(2'd3));
        chk("wide_flush_cnt", 64'(flush_cnt), 64'(16'd5));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
